// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the dual-lane data-memory port arbiter:
// FSM states, conflict classes and default widths.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_IDX_W  = 8;
  localparam int DMEM_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_RAW  = 2'd1,
    CF_WAW  = 2'd2,
    CF_WAR  = 2'd3
  } conflict_t;

endpackage

// File: rtl/dmem_port_arbiter_detect.sv
// Classifies a same-index pair of lane requests by hazard type.
// Lane 1 is older, so "RAW" means lane-1 store followed by lane-2 load.
module dmem_conflict_detect
  import dmem_port_arbiter_pkg::*;
#(
  parameter int IDX_W = DMEM_IDX_W
) (
  input  logic             i_valid_1,
  input  logic             i_write_1,
  input  logic [IDX_W-1:0] i_idx_1,
  input  logic             i_valid_2,
  input  logic             i_write_2,
  input  logic [IDX_W-1:0] i_idx_2,
  output conflict_t        o_conflict
);

  logic w_match;

  assign w_match = i_valid_1 & i_valid_2 & (i_idx_1 == i_idx_2);

  always_comb begin
    o_conflict = CF_NONE;
    if (w_match) begin
      case ({i_write_1, i_write_2})
        2'b10:   o_conflict = CF_RAW;
        2'b11:   o_conflict = CF_WAW;
        2'b01:   o_conflict = CF_WAR;
        default: o_conflict = CF_NONE;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the two MEM-stage lanes onto a dual-port data memory, splitting
// same-word store->load pairs over two cycles and dropping the older of two stores.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int IDX_W  = DMEM_IDX_W,
  parameter int CNT_W  = DMEM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_1,
  input  logic              req_write_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  input  logic              req_valid_2,
  input  logic              req_write_2,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [DATA_W-1:0] req_wdata_2,
  output logic [DATA_W-1:0] rdata_1,
  output logic [DATA_W-1:0] rdata_2,
  output logic              rdata_valid_1,
  output logic              rdata_valid_2,
  output logic              stall,
  output logic              mem_read_1,
  output logic              mem_read_2,
  output logic              mem_write_1,
  output logic              mem_write_2,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [ADDR_W-1:0] mem_addr_2,
  output logic [DATA_W-1:0] mem_wdata_1,
  output logic [DATA_W-1:0] mem_wdata_2,
  input  logic [DATA_W-1:0] mem_rdata_1,
  input  logic [DATA_W-1:0] mem_rdata_2,
  output logic [CNT_W-1:0]  conflict_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  conflict_t         w_conflict;
  logic [ADDR_W-1:0] r_hold_addr;
  logic              r_rdata_valid_1;
  logic              r_rdata_valid_2;
  logic [CNT_W-1:0]  r_count;
  logic              w_count_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  dmem_conflict_detect #(
    .IDX_W(IDX_W)
  ) u_detect (
    .i_valid_1  (req_valid_1),
    .i_write_1  (req_write_1),
    .i_idx_1    (req_addr_1[IDX_W-1:0]),
    .i_valid_2  (req_valid_2),
    .i_write_2  (req_write_2),
    .i_idx_2    (req_addr_2[IDX_W-1:0]),
    .o_conflict (w_conflict)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_inc = 1'b0;
    stall       = 1'b0;
    mem_read_1  = 1'b0;
    mem_read_2  = 1'b0;
    mem_write_1 = 1'b0;
    mem_write_2 = 1'b0;
    mem_addr_1  = req_addr_1;
    mem_addr_2  = req_addr_2;
    mem_wdata_1 = req_wdata_1;
    mem_wdata_2 = req_wdata_2;
    if (r_state == ST_SPLIT) begin
      mem_read_2  = 1'b1;
      mem_addr_2  = r_hold_addr;
      w_state_nxt = ST_IDLE;
    end else begin
      mem_read_1  = req_valid_1 & ~req_write_1;
      mem_write_1 = req_valid_1 &  req_write_1;
      mem_read_2  = req_valid_2 & ~req_write_2;
      mem_write_2 = req_valid_2 &  req_write_2;
      case (w_conflict)
        CF_RAW: begin
          mem_read_2  = 1'b0;
          stall       = 1'b1;
          w_state_nxt = ST_SPLIT;
          w_count_inc = 1'b1;
        end
        CF_WAW: begin
          mem_write_1 = 1'b0;
          w_count_inc = 1'b1;
        end
        default: ;
      endcase
    end
    // Strobes must not reach the memory while reset is asserted.
    if (rst) begin
      stall       = 1'b0;
      mem_read_1  = 1'b0;
      mem_read_2  = 1'b0;
      mem_write_1 = 1'b0;
      mem_write_2 = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_hold_addr     <= '0;
      r_rdata_valid_1 <= 1'b0;
      r_rdata_valid_2 <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_rdata_valid_1 <= mem_read_1;
      r_rdata_valid_2 <= mem_read_2;
      if (r_state == ST_IDLE && w_conflict == CF_RAW) begin
        r_hold_addr <= req_addr_2;
      end
      if (w_count_inc) begin
        r_count <= sat_inc(r_count);
      end
    end
  end

  assign rdata_1        = mem_rdata_1;
  assign rdata_2        = mem_rdata_2;
  assign rdata_valid_1  = r_rdata_valid_1;
  assign rdata_valid_2  = r_rdata_valid_2;
  assign conflict_count = r_count;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural dual-port
// memory (registered reads, read-before-write) hung off the mem_* ports.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              req_valid_1, req_write_1, req_valid_2, req_write_2;
  logic [ADDR_W-1:0] req_addr_1, req_addr_2;
  logic [DATA_W-1:0] req_wdata_1, req_wdata_2;
  logic [DATA_W-1:0] rdata_1, rdata_2;
  logic              rdata_valid_1, rdata_valid_2, stall;
  logic              mem_read_1, mem_read_2, mem_write_1, mem_write_2;
  logic [ADDR_W-1:0] mem_addr_1, mem_addr_2;
  logic [DATA_W-1:0] mem_wdata_1, mem_wdata_2;
  logic [DATA_W-1:0] mem_rdata_1, mem_rdata_2;
  logic [CNT_W-1:0]  conflict_count;

  int n_checks;
  int n_fail;

  logic [DATA_W-1:0] mem [0:255];

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_1(req_valid_1), .req_write_1(req_write_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .req_valid_2(req_valid_2), .req_write_2(req_write_2),
    .req_addr_2(req_addr_2), .req_wdata_2(req_wdata_2),
    .rdata_1(rdata_1), .rdata_2(rdata_2),
    .rdata_valid_1(rdata_valid_1), .rdata_valid_2(rdata_valid_2),
    .stall(stall),
    .mem_read_1(mem_read_1), .mem_read_2(mem_read_2),
    .mem_write_1(mem_write_1), .mem_write_2(mem_write_2),
    .mem_addr_1(mem_addr_1), .mem_addr_2(mem_addr_2),
    .mem_wdata_1(mem_wdata_1), .mem_wdata_2(mem_wdata_2),
    .mem_rdata_1(mem_rdata_1), .mem_rdata_2(mem_rdata_2),
    .conflict_count(conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read_1)  mem_rdata_1 <= mem[mem_addr_1[IDX_W-1:0]];
    if (mem_read_2)  mem_rdata_2 <= mem[mem_addr_2[IDX_W-1:0]];
    if (mem_write_1) mem[mem_addr_1[IDX_W-1:0]] <= mem_wdata_1;
    if (mem_write_2) mem[mem_addr_2[IDX_W-1:0]] <= mem_wdata_2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic v2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    req_valid_1 = v1; req_write_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
    req_valid_2 = v2; req_write_2 = w2; req_addr_2 = a2; req_wdata_2 = d2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_req(1, 1, 32'h10, 32'h1, 1, 0, 32'h10, 32'h0);
    mem_rdata_1 = '0;
    mem_rdata_2 = '0;
    @(negedge clk);
    check_eq("rst_stall", {31'b0, stall}, 0);
    check_eq("rst_wr1", {31'b0, mem_write_1}, 0);
    check_eq("rst_rv2", {31'b0, rdata_valid_2}, 0);
    check_eq("rst_count", {28'b0, conflict_count}, 0);
    step();
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // 1: RAW split
    set_req(1, 1, 32'h10, 32'hDEAD, 1, 0, 32'h10, 32'h0);
    @(negedge clk);
    check_eq("t1_stall", {31'b0, stall}, 1);
    check_eq("t1_wr1", {31'b0, mem_write_1}, 1);
    check_eq("t1_rd2", {31'b0, mem_read_2}, 0);
    step();
    @(negedge clk);
    check_eq("t1_split_rd2", {31'b0, mem_read_2}, 1);
    check_eq("t1_split_addr2", mem_addr_2, 32'h10);
    check_eq("t1_split_stall", {31'b0, stall}, 0);
    check_eq("t1_split_wr1", {31'b0, mem_write_1}, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t1_rv2", {31'b0, rdata_valid_2}, 1);
    check_eq("t1_rdata2", rdata_2, 32'hDEAD);
    check_eq("t1_count", {28'b0, conflict_count}, 1);
    step();

    // 2: WAW keeps lane 2
    set_req(1, 1, 32'h20, 32'h1111, 1, 1, 32'h20, 32'h2222);
    @(negedge clk);
    check_eq("t2_wr1", {31'b0, mem_write_1}, 0);
    check_eq("t2_wr2", {31'b0, mem_write_2}, 1);
    check_eq("t2_stall", {31'b0, stall}, 0);
    step();
    set_req(1, 0, 32'h20, 0, 0, 0, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t2_rv1", {31'b0, rdata_valid_1}, 1);
    check_eq("t2_rdata1", rdata_1, 32'h2222);
    check_eq("t2_count", {28'b0, conflict_count}, 2);
    step();

    // 3: WAR, load sees old data
    set_req(1, 1, 32'h30, 32'h5, 0, 0, 0, 0);
    step();
    set_req(1, 0, 32'h30, 0, 1, 1, 32'h30, 32'h9);
    @(negedge clk);
    check_eq("t3_stall", {31'b0, stall}, 0);
    check_eq("t3_rd1", {31'b0, mem_read_1}, 1);
    check_eq("t3_wr2", {31'b0, mem_write_2}, 1);
    step();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t3_rdata1", rdata_1, 32'h5);
    check_eq("t3_rv1", {31'b0, rdata_valid_1}, 1);
    check_eq("t3_count", {28'b0, conflict_count}, 2);
    step();

    // 4: index-only compare
    set_req(1, 1, 32'h140, 32'h77, 1, 0, 32'h40, 0);
    @(negedge clk);
    check_eq("t4_stall", {31'b0, stall}, 1);
    check_eq("t4_rd2", {31'b0, mem_read_2}, 0);
    step();
    @(negedge clk);
    check_eq("t4_split_addr2", mem_addr_2, 32'h40);
    step();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t4_count", {28'b0, conflict_count}, 3);
    check_eq("t4_rdata2", rdata_2, 32'h77);
    step();

    // 5: reset during SPLIT
    set_req(1, 1, 32'h50, 32'hAB, 1, 0, 32'h50, 0);
    step();
    rst = 1'b1;
    #1;
    check_eq("t5_rd2_in_rst", {31'b0, mem_read_2}, 0);
    check_eq("t5_stall_in_rst", {31'b0, stall}, 0);
    step();
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t5_rd2_idle", {31'b0, mem_read_2}, 0);
    check_eq("t5_count", {28'b0, conflict_count}, 0);
    step();
    @(negedge clk);
    check_eq("t5_rv2", {31'b0, rdata_valid_2}, 0);

    // 6: saturation after 2^CNT_W+3 RAW conflicts
    for (int i = 0; i < 19; i++) begin
      set_req(1, 1, 32'h60, i, 1, 0, 32'h60, 0);
      step();
      step();
      if (i == 14) check_eq("t6_count15", {28'b0, conflict_count}, 15);
    end
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("t6_sat", {28'b0, conflict_count}, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
